// File: rtl/dac_switch_sequencer_pkg.sv
// Shared types and helpers for the DAC reconfiguration sequencer.
package dac_switch_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_MUTE     = 3'd2,
        S_RESET    = 3'd3,
        S_APPLY    = 3'd4,
        S_SETTLE   = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic [1:0] f;
        logic       fs48;
        logic       dsd_n;
        logic [1:0] mode;
        logic       nos;
        logic       rsvd;
    } snos_cfg_t;

    localparam int SNOS_CFG_W = $bits(snos_cfg_t);

    // Terminal count for a wait of w cycles; 0 and 1 both give a single-cycle state.
    function automatic int wait_lim(input int w);
        return (w <= 1) ? 0 : w - 1;
    endfunction

endpackage

// File: rtl/dac_switch_sequencer_sync.sv
// Two-flop synchronizer for a bundle of asynchronous inputs.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dac_switch_sequencer.sv
// Click-free DAC reconfiguration: mute, reset, apply config, settle, unmute on every
// stable change of the MCU format pins or on an MCU reset request.
module dac_switch_sequencer
    import dac_switch_sequencer_pkg::*;
#(
    parameter int CFG_W       = SNOS_CFG_W,
    parameter int DEBOUNCE    = 64,
    parameter int MUTE_WAIT   = 4096,
    parameter int RESET_WIDTH = 1024,
    parameter int SETTLE_WAIT = 8192,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [CFG_W-1:0] cfg_in,
    input  logic             mcu_mute,
    input  logic             mcu_dac_reset,
    output logic [CFG_W-1:0] cfg_out,
    output logic             mute_out,
    output logic             dac_reset_out,
    output logic             busy,
    output logic [2:0]       state
);

    localparam int SYNC_W = CFG_W + 2;
    localparam int STAB_W = $clog2(DEBOUNCE + 2);

    localparam logic [CNT_W-1:0]  DEB_LIM  = CNT_W'(wait_lim(DEBOUNCE));
    localparam logic [CNT_W-1:0]  MUTE_LIM = CNT_W'(wait_lim(MUTE_WAIT));
    localparam logic [CNT_W-1:0]  RST_LIM  = CNT_W'(wait_lim(RESET_WIDTH));
    localparam logic [CNT_W-1:0]  SET_LIM  = CNT_W'(wait_lim(SETTLE_WAIT));
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [STAB_W-1:0] STAB_LIM = STAB_W'(wait_lim(DEBOUNCE));
    localparam logic [STAB_W-1:0] STAB_MAX = '1;

    logic [SYNC_W-1:0] sync_q;
    logic [CFG_W-1:0]  cfg_s;
    logic              mute_s;
    logic              rst_s;

    sync_2ff #(.W(SYNC_W)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      ({cfg_in, mcu_mute, mcu_dac_reset}),
        .q      (sync_q)
    );

    assign cfg_s  = sync_q[SYNC_W-1:2];
    assign mute_s = sync_q[1];
    assign rst_s  = sync_q[0];

    seq_state_t        st, st_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CFG_W-1:0]  cand;
    logic [CFG_W-1:0]  pend;
    logic [STAB_W-1:0] stab;
    logic              use_sync;
    logic              deb_restart;
    logic              cand_load;
    logic              mute_d;
    logic              dac_d;
    logic              stable;
    logic [CFG_W-1:0]  apply_val;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) st <= S_RESET;
        else         st <= st_nx;
    end

    // Next-state logic
    always_comb begin
        st_nx       = st;
        deb_restart = 1'b0;
        case (st)
            S_IDLE: begin
                if (cfg_s != cfg_out) st_nx = S_DEBOUNCE;
                else if (rst_s)       st_nx = S_MUTE;
            end
            S_DEBOUNCE: begin
                if (cfg_s == cfg_out)     st_nx = S_IDLE;
                else if (cfg_s != cand)   deb_restart = 1'b1;
                else if (cnt >= DEB_LIM)  st_nx = S_MUTE;
            end
            S_MUTE:   if (cnt >= MUTE_LIM) st_nx = S_RESET;
            S_RESET:  if (cnt >= RST_LIM && !rst_s) st_nx = S_APPLY;
            S_APPLY:  st_nx = S_SETTLE;
            S_SETTLE: begin
                if (cnt >= SET_LIM) st_nx = (cfg_s != cfg_out) ? S_DEBOUNCE : S_IDLE;
            end
            default:  st_nx = S_RESET;
        endcase
        cand_load = (st_nx == S_DEBOUNCE) && ((st_nx != st) || deb_restart);
    end

    // Output / datapath next values
    always_comb begin
        busy  = (st != S_IDLE);
        state = st;
        dac_d = (st_nx == S_RESET);
        case (st_nx)
            S_IDLE:     mute_d = mute_s;
            S_DEBOUNCE: mute_d = mute_out | mute_s;
            default:    mute_d = 1'b1;
        endcase
        // A change that arrived mid-sequence wins only once it has been stable long enough.
        stable    = (cfg_s == pend) && (stab >= STAB_LIM);
        apply_val = use_sync ? cfg_s : (stable ? pend : cand);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt           <= '0;
            cand          <= '0;
            pend          <= '0;
            stab          <= '0;
            cfg_out       <= '0;
            mute_out      <= 1'b1;
            dac_reset_out <= 1'b1;
            use_sync      <= 1'b1;
        end else begin
            if ((st_nx != st) || deb_restart) cnt <= '0;
            else if (cnt != CNT_MAX)          cnt <= cnt + CNT_W'(1);

            if (cand_load) cand <= cfg_s;

            if (cfg_s != pend) begin
                pend <= cfg_s;
                stab <= '0;
            end else if (stab != STAB_MAX) begin
                stab <= stab + STAB_W'(1);
            end

            if (st == S_APPLY) cfg_out <= apply_val;

            mute_out      <= mute_d;
            dac_reset_out <= dac_d;

            if (st == S_IDLE && st_nx == S_MUTE)             use_sync <= 1'b1;
            else if (st_nx == S_DEBOUNCE || st == S_APPLY)   use_sync <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dac_switch_sequencer.sv
// Scoreboard bench: expected state transitions are queued with stimulus and checked by a monitor.
module tb_dac_switch_sequencer;
    import dac_switch_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] cfg_in = 8'h2C;
    logic       mcu_mute = 1'b0;
    logic       mcu_dac_reset = 1'b0;
    logic [7:0] cfg_out;
    logic       mute_out;
    logic       dac_reset_out;
    logic       busy;
    logic [2:0] state;

    dac_switch_sequencer #(
        .CFG_W(8), .DEBOUNCE(4), .MUTE_WAIT(8), .RESET_WIDTH(6), .SETTLE_WAIT(10), .CNT_W(16)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .cfg_in        (cfg_in),
        .mcu_mute      (mcu_mute),
        .mcu_dac_reset (mcu_dac_reset),
        .cfg_out       (cfg_out),
        .mute_out      (mute_out),
        .dac_reset_out (dac_reset_out),
        .busy          (busy),
        .state         (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic [7:0] cfg;
        logic       mute;
        logic       dac;
        int         dwell;   // cycles spent in the previous state; -1 = don't care
    } exp_t;

    exp_t exp_q[$];
    int mon_checks = 0, mon_passed = 0;
    int dir_checks = 0, dir_passed = 0;

    task automatic push(input logic [2:0] s, input logic [7:0] c, input logic m,
                        input logic d, input int dw);
        exp_t e;
        e.st = s; e.cfg = c; e.mute = m; e.dac = d; e.dwell = dw;
        exp_q.push_back(e);
    endtask

    // Monitor: samples just after each rising edge, checks every state transition.
    logic [2:0] prev_st = 3'd0;
    int dwell = 0;
    int tr_idx = 0;
    always @(posedge clk) begin
        exp_t e;
        logic ok;
        #1;
        if (!resetn) begin
            prev_st = state;
            dwell   = 1;
        end else if (state == prev_st) begin
            dwell++;
        end else begin
            mon_checks++;
            tr_idx++;
            if (exp_q.size() == 0) begin
                $display("FAIL transition#%0d unexpected: st %0d -> %0d after %0d cycles",
                         tr_idx, prev_st, state, dwell);
            end else begin
                e  = exp_q.pop_front();
                ok = (state == e.st) && (cfg_out == e.cfg) && (mute_out == e.mute) &&
                     (dac_reset_out == e.dac) && (busy == (e.st != S_IDLE)) &&
                     (e.dwell < 0 || dwell == e.dwell);
                if (ok) mon_passed++;
                else $display("FAIL transition#%0d: got st=%0d cfg=%h mute=%b dac=%b busy=%b dwell=%0d, want st=%0d cfg=%h mute=%b dac=%b dwell=%0d",
                              tr_idx, state, cfg_out, mute_out, dac_reset_out, busy, dwell,
                              e.st, e.cfg, e.mute, e.dac, e.dwell);
            end
            prev_st = state;
            dwell   = 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        dir_checks++;
        if (act == want) dir_passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, want);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (state != s && n < budget);
        dir_checks++;
        if (state == s) dir_passed++;
        else $display("FAIL wait_%s: state=%0d never reached %0d", nm, state, s);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || state != S_IDLE) && n < 300);
        dir_checks++;
        if (exp_q.size() == 0 && state == S_IDLE) dir_passed++;
        else $display("FAIL drain_%s: state=%0d pending=%0d want idle/0", nm, state, exp_q.size());
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // 1 power-up
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 32'(S_RESET));
        chk("rst_mute", 32'(mute_out), 32'd1);
        chk("rst_dac", 32'(dac_reset_out), 32'd1);
        chk("rst_cfg", 32'(cfg_out), 32'h00);
        chk("rst_busy", 32'(busy), 32'd1);
        push(S_APPLY,  8'h00, 1, 0, 6);
        push(S_SETTLE, 8'h2C, 1, 0, 1);
        push(S_IDLE,   8'h2C, 0, 0, 10);
        resetn = 1'b1;
        drain("powerup");

        // 3 glitch shorter than debounce
        push(S_DEBOUNCE, 8'h2C, 0, 0, -1);
        push(S_IDLE,     8'h2C, 0, 0, 2);
        cfg_in = 8'h2D;
        repeat (2) @(negedge clk);
        cfg_in = 8'h2C;
        drain("glitch");

        // 2 clean change
        push(S_DEBOUNCE, 8'h2C, 0, 0, -1);
        push(S_MUTE,     8'h2C, 1, 0, 4);
        push(S_RESET,    8'h2C, 1, 1, 8);
        push(S_APPLY,    8'h2C, 1, 0, 6);
        push(S_SETTLE,   8'h2D, 1, 0, 1);
        push(S_IDLE,     8'h2D, 0, 0, 10);
        cfg_in = 8'h2D;
        drain("clean");

        // 4a change during S_RESET, stable long enough to be applied directly
        push(S_DEBOUNCE, 8'h2D, 0, 0, -1);
        push(S_MUTE,     8'h2D, 1, 0, 4);
        push(S_RESET,    8'h2D, 1, 1, 8);
        push(S_APPLY,    8'h2D, 1, 0, 6);
        push(S_SETTLE,   8'h2E, 1, 0, 1);
        push(S_IDLE,     8'h2E, 0, 0, 10);
        cfg_in = 8'h2F;
        wait_state(S_RESET, 50, "reset4a");
        cfg_in = 8'h2E;
        drain("chg_in_reset");

        // 4b change in the last two cycles of S_SETTLE -> second sequence, mute held
        push(S_DEBOUNCE, 8'h2E, 0, 0, -1);
        push(S_MUTE,     8'h2E, 1, 0, 4);
        push(S_RESET,    8'h2E, 1, 1, 8);
        push(S_APPLY,    8'h2E, 1, 0, 6);
        push(S_SETTLE,   8'h2F, 1, 0, 1);
        push(S_DEBOUNCE, 8'h2F, 1, 0, 10);
        push(S_MUTE,     8'h2F, 1, 0, 4);
        push(S_RESET,    8'h2F, 1, 1, 8);
        push(S_APPLY,    8'h2F, 1, 0, 6);
        push(S_SETTLE,   8'h2C, 1, 0, 1);
        push(S_IDLE,     8'h2C, 0, 0, 10);
        cfg_in = 8'h2F;
        wait_state(S_SETTLE, 60, "settle4b");
        repeat (6) @(negedge clk);
        cfg_in = 8'h2C;
        drain("chg_late_settle");

        // 5 MCU reset held 20 cycles: S_RESET stretched to the synced release
        push(S_MUTE,   8'h2C, 1, 0, -1);
        push(S_RESET,  8'h2C, 1, 1, 8);
        push(S_APPLY,  8'h2C, 1, 0, 12);
        push(S_SETTLE, 8'h2C, 1, 0, 1);
        push(S_IDLE,   8'h2C, 0, 0, 10);
        mcu_dac_reset = 1'b1;
        repeat (20) @(negedge clk);
        mcu_dac_reset = 1'b0;
        drain("mcu_reset");

        // 6 async resetn during S_SETTLE
        push(S_DEBOUNCE, 8'h2C, 0, 0, -1);
        push(S_MUTE,     8'h2C, 1, 0, 4);
        push(S_RESET,    8'h2C, 1, 1, 8);
        push(S_APPLY,    8'h2C, 1, 0, 6);
        push(S_SETTLE,   8'h2D, 1, 0, 1);
        cfg_in = 8'h2D;
        wait_state(S_SETTLE, 60, "settle6");
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("async_state", 32'(state), 32'(S_RESET));
        chk("async_mute", 32'(mute_out), 32'd1);
        chk("async_dac", 32'(dac_reset_out), 32'd1);
        chk("async_cfg", 32'(cfg_out), 32'h00);
        chk("async_busy", 32'(busy), 32'd1);
        chk("async_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        push(S_APPLY,  8'h00, 1, 0, 6);
        push(S_SETTLE, 8'h2D, 1, 0, 1);
        push(S_IDLE,   8'h2D, 0, 0, 10);
        resetn = 1'b1;
        drain("after_async");

        $display("%0d/%0d checks passed", mon_passed + dir_passed, mon_checks + dir_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
